// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Purpose  : EX-stage request / HI-LO result bundle for muldiv_unit.
// Revision : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : HI/LO multiply/divide unit; radix-2 shift-add multiply and
//            restoring divide on magnitudes with a final sign-fix cycle.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    muldiv_if.slave   bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi_p;
    logic [WIDTH-1:0]   r_lo_p;
    logic [WIDTH-1:0]   r_opd;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_accept;
    logic               w_launch;
    logic               w_fast;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_fix_wr;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_is_mul = (bus.op[2:1] == 2'b00);
    assign w_is_div = (bus.op[2:1] == 2'b01);
    assign w_signed = ~bus.op[0];
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_mthi   = w_accept && (bus.op == 3'b100);
    assign w_mtlo   = w_accept && (bus.op == 3'b101);
    assign w_fast   = w_accept && w_is_mul && FAST_MUL;
    assign w_launch = w_accept && (w_is_div || (w_is_mul && !FAST_MUL));

    assign w_a_neg  = w_signed && bus.src_a[WIDTH-1];
    assign w_b_neg  = w_signed && bus.src_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_b_mag  = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;

    // Multiply: r_hi_p accumulates, r_lo_p holds the multiplier shifting out.
    assign w_sum    = {1'b0, r_hi_p} + (r_lo_p[0] ? {1'b0, r_opd} : '0);
    // Divide: r_hi_p is the partial remainder, r_lo_p dividend/quotient.
    assign w_shift  = {r_hi_p, r_lo_p[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_opd});
    assign w_diff   = w_shift[WIDTH-1:0] - r_opd;

    assign w_prod_mag = {r_hi_p, r_lo_p};
    assign w_prod     = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;
    assign w_quo      = r_dz ? '1 : (r_neg_q ? (~r_lo_p + 1'b1) : r_lo_p);
    assign w_rem      = r_neg_r ? (~r_hi_p + 1'b1) : r_hi_p;

    generate
        if (FAST_MUL) begin : g_fast_mul
            logic [2*WIDTH-1:0] w_ext_a;
            logic [2*WIDTH-1:0] w_ext_b;
            assign w_ext_a     = {{WIDTH{w_signed && bus.src_a[WIDTH-1]}}, bus.src_a};
            assign w_ext_b     = {{WIDTH{w_signed && bus.src_b[WIDTH-1]}}, bus.src_b};
            assign w_fast_prod = w_ext_a * w_ext_b;
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_fix_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                w_fix_wr    = !bus.flush;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi_p   <= '0;
            r_lo_p   <= '0;
            r_opd    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_fast || w_fix_wr;

            if (w_launch) begin
                r_cnt    <= '0;
                r_hi_p   <= '0;
                r_lo_p   <= w_is_div ? w_a_mag : w_b_mag;
                r_opd    <= w_is_div ? w_b_mag : w_a_mag;
                r_is_div <= w_is_div;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dz     <= (bus.src_b == '0);
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_is_div) begin
                    r_hi_p <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_lo_p <= {r_lo_p[WIDTH-2:0], w_ge};
                end else begin
                    r_hi_p <= w_sum[WIDTH:1];
                    r_lo_p <= {w_sum[0], r_lo_p[WIDTH-1:1]};
                end
            end

            if (w_mthi) begin
                r_hi <= bus.src_a;
            end else if (w_mtlo) begin
                r_lo <= bus.src_a;
            end else if (w_fast) begin
                {r_hi, r_lo} <= w_fast_prod;
            end else if (w_fix_wr) begin
                if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    {r_hi, r_lo} <= w_prod;
                end
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit (iterative and fast-multiply).
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) m0 ();
    muldiv_if #(.WIDTH(32)) m1 ();

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m0.slave)
    );

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (m1.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb[$];

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb;
        logic signed [31:0] sa, sb_, q, r;
        sa = a;
        sb_ = b;
        case (op)
            3'd0: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            3'd1: return {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb_;
                r = sa % sb_;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic issue(input bit fast, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (fast) begin
            m1.start = 1'b1; m1.op = op; m1.src_a = a; m1.src_b = b;
        end else begin
            m0.start = 1'b1; m0.op = op; m0.src_a = a; m0.src_b = b;
        end
        @(negedge clk);
        m0.start = 1'b0; m1.start = 1'b0;
        m0.src_a = ~a;   m0.src_b = ~b;
        m1.src_a = ~a;   m1.src_b = ~b;
    endtask

    task automatic wait_done(input bit fast, output int lat, output int busy_cyc,
                             output bit seen, output bit overlap,
                             output logic [31:0] h, output logic [31:0] l);
        logic b, d;
        seen = 1'b0; overlap = 1'b0; busy_cyc = 0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            b = fast ? m1.busy : m0.busy;
            d = fast ? m1.done : m0.done;
            if (b && d) overlap = 1'b1;
            if (b) busy_cyc++;
            if (d) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            @(negedge clk);
        end
        h = fast ? m1.hi : m0.hi;
        l = fast ? m1.lo : m0.lo;
    endtask

    task automatic test_reset();
        m0.start = 0; m0.op = 0; m0.src_a = 0; m0.src_b = 0; m0.flush = 0;
        m1.start = 0; m1.op = 0; m1.src_a = 0; m1.src_b = 0; m1.flush = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({m0.hi, m0.lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo got=%h exp=0", {m0.hi, m0.lo}); end
        n_tests++;
        if ({m0.busy, m0.done, m1.busy, m1.done} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {m0.busy, m0.done, m1.busy, m1.done});
        end
    endtask

    task automatic test_multu_max();
        int lat, bc; bit seen, ov; logic [31:0] h, l; logic [63:0] exp;
        sb.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        issue(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, bc, seen, ov, h, l);
        exp = sb.pop_front();
        n_tests++;
        if (!seen || lat !== 33) begin n_fail++; $display("FAIL multu_latency got=%0d exp=33", lat); end
        n_tests++;
        if (bc !== 33 || ov) begin n_fail++; $display("FAIL multu_busy got=%0d overlap=%0b exp=33", bc, ov); end
        n_tests++;
        if ({h, l} !== exp) begin n_fail++; $display("FAIL multu_result got=%h exp=%h", {h, l}, exp); end
    endtask

    task automatic test_mult_signed();
        int lat, bc; bit seen, ov; logic [31:0] h, l; logic [63:0] exp;
        for (int f = 0; f < 2; f++) begin
            sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
            issue(f[0], 3'd0, -32'sd7, 32'd3);
            wait_done(f[0], lat, bc, seen, ov, h, l);
            exp = sb.pop_front();
            n_tests++;
            if (!seen || lat !== (f ? 0 : 33) || bc !== (f ? 0 : 33) || ov) begin
                n_fail++; $display("FAIL mult_timing fast=%0d lat=%0d busy=%0d exp_lat=%0d", f, lat, bc, f ? 0 : 33);
            end
            n_tests++;
            if ({h, l} !== exp) begin n_fail++; $display("FAIL mult_result fast=%0d got=%h exp=%h", f, {h, l}, exp); end
        end
    endtask

    task automatic test_div();
        int lat, bc; bit seen, ov; logic [31:0] h, l; logic [63:0] exp;
        logic [31:0] av[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] bv[3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [2:0]  ov_[3] = '{3'd2, 3'd2, 3'd3};
        logic [63:0] ev[3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                               {32'h0000_0064, 32'hFFFF_FFFF}};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ev[i]);
            issue(1'b0, ov_[i], av[i], bv[i]);
            wait_done(1'b0, lat, bc, seen, ov, h, l);
            exp = sb.pop_front();
            n_tests++;
            if (!seen || lat !== 33 || bc !== 33) begin
                n_fail++; $display("FAIL div_latency idx=%0d lat=%0d busy=%0d exp=33", i, lat, bc);
            end
            n_tests++;
            if ({h, l} !== exp) begin n_fail++; $display("FAIL div_result idx=%0d got=%h exp=%h", i, {h, l}, exp); end
        end
    endtask

    task automatic test_random();
        int lat, bc; bit seen, ov; logic [31:0] h, l, a, b; logic [63:0] exp; logic [2:0] op;
        bit fast;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i % 5 == 1) b = -b;
            fast = (op[1] == 1'b0) && i[0];
            sb.push_back(model(op, a, b));
            issue(fast, op, a, b);
            wait_done(fast, lat, bc, seen, ov, h, l);
            exp = sb.pop_front();
            n_tests++;
            if (!seen || {h, l} !== exp) begin
                n_fail++; $display("FAIL random op=%0d a=%h b=%h got=%h exp=%h", op, a, b, {h, l}, exp);
            end
        end
    endtask

    task automatic test_mt_flush();
        int dones;
        issue(1'b0, 3'd4, 32'h1234, 32'h0);
        n_tests++;
        if (m0.hi !== 32'h1234 || m0.busy || m0.done) begin
            n_fail++; $display("FAIL mthi got=%h busy=%0b done=%0b exp=00001234", m0.hi, m0.busy, m0.done);
        end
        issue(1'b0, 3'd5, 32'h5678, 32'h0);
        n_tests++;
        if (m0.lo !== 32'h5678 || m0.busy || m0.done) begin
            n_fail++; $display("FAIL mtlo got=%h exp=00005678", m0.lo);
        end
        m0.flush = 1'b1;
        issue(1'b0, 3'd4, 32'hDEAD, 32'h0);
        m0.flush = 1'b0;
        n_tests++;
        if (m0.hi !== 32'h1234 || m0.busy) begin
            n_fail++; $display("FAIL flush_start got=%h busy=%0b exp=00001234", m0.hi, m0.busy);
        end
        issue(1'b0, 3'd3, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        m0.flush = 1'b1;
        @(negedge clk);
        m0.flush = 1'b0;
        n_tests++;
        if (m0.busy !== 1'b0 || m0.done !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy busy=%0b done=%0b exp=0", m0.busy, m0.done);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (m0.done) dones++;
            @(negedge clk);
        end
        n_tests++;
        if (dones !== 0 || m0.hi !== 32'h1234 || m0.lo !== 32'h5678) begin
            n_fail++; $display("FAIL flush_keep dones=%0d got=%h exp=0000123400005678", dones, {m0.hi, m0.lo});
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc; bit seen, ov; logic [31:0] h, l; logic [63:0] exp;
        sb.push_back(model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        issue(1'b0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(negedge clk);
        issue(1'b0, 3'd5, 32'hAAAA, 32'h0);
        wait_done(1'b0, lat, bc, seen, ov, h, l);
        exp = sb.pop_front();
        n_tests++;
        if (!seen || {h, l} !== exp) begin
            n_fail++; $display("FAIL busy_ignore got=%h exp=%h", {h, l}, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit seen, ov; logic [31:0] h, l; logic [63:0] exp;
        sb.push_back(model(3'd2, 32'hFFFF_FF00, 32'd9));
        sb.push_back(model(3'd0, 32'h7FFF_FFFF, 32'h8000_0000));
        issue(1'b0, 3'd2, 32'hFFFF_FF00, 32'd9);
        wait_done(1'b0, lat, bc, seen, ov, h, l);
        exp = sb.pop_front();
        n_tests++;
        if (!seen || {h, l} !== exp) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", {h, l}, exp); end
        issue(1'b0, 3'd0, 32'h7FFF_FFFF, 32'h8000_0000);
        wait_done(1'b0, lat, bc, seen, ov, h, l);
        exp = sb.pop_front();
        n_tests++;
        if (!seen || lat !== 33 || {h, l} !== exp) begin
            n_fail++; $display("FAIL b2b_second lat=%0d got=%h exp=%h", lat, {h, l}, exp);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'd1, 32'h0000_0FFF, 32'h0000_0FFF);
        repeat (19) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (m0.hi !== 32'h0 || m0.lo !== 32'h0 || m0.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got=%h busy=%0b exp=0", {m0.hi, m0.lo}, m0.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (m0.done !== 1'b0 || m0.busy !== 1'b0 || {m0.hi, m0.lo} !== 64'h0) begin
            n_fail++; $display("FAIL reset_after done=%0b busy=%0b got=%h exp=0", m0.done, m0.busy, {m0.hi, m0.lo});
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div();
        test_random();
        test_mt_flush();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers for the 5-stage MIPS pipeline.
- Driven from the EX stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and runs iterative radix-2 multiply or restoring divide over WIDTH cycles.
- Asserts busy so the hazard logic can stall MFHI/MFLO and further mul/div ops.
- Supports flush on branch/exception squash and an optional single-cycle multiply mode.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, at least 4).
- FAST_MUL, 0: 1 = MULT/MULTU complete combinationally in one cycle; 0 = iterative over WIDTH cycles.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  op request, sampled on the rising edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, treated as no-op
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MTxx data)
- src_b  input  WIDTH  rt operand (divisor / multiplier)
- flush  input  1  abort the in-flight operation
- busy  output  1  registered; high while an iterative op is in flight
- done  output  1  registered one-cycle pulse; HI/LO were just updated by a mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation discards all partial results.
- States: IDLE, CALC, FIX.

IDLE:
- start=1 and flush=0 at edge t0:
  - MTHI writes hi=src_a; MTLO writes lo=src_a. No busy, no done.
  - Reserved op codes are ignored.
  - MULT/MULTU with FAST_MUL=1: {hi,lo} = full 2*WIDTH product at t0; done=1 for the cycle after t0; busy stays 0.
  - Any other mul/div: latch operand magnitudes (absolute value for signed ops) and result-sign flags; counter=0; go to CALC; busy=1 from t0.
- Operands are captured at t0; later changes to src_a/src_b have no effect.

CALC:
- One shift-add (multiply) or restore-subtract (divide) step per edge; counter increments.
- After WIDTH iterations (edges t1..tW), go to FIX.
- Partial results live in internal registers only; hi/lo are unchanged until FIX.

FIX, edge t(W+1):
- Apply sign correction and write hi/lo; done=1 for the following cycle; busy=0; return to IDLE.
- A new start is accepted no earlier than the edge after busy falls.

Arithmetic:
- MULT/MULTU: {hi,lo} = signed/unsigned 2*WIDTH product.
- DIV/DIVU: lo = quotient, hi = remainder.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: hi = src_a, lo = all ones. Runs full latency, no error flag.
- Signed most-negative / -1: lo = most-negative value (wraps), hi = 0.

Boundaries:
- start while busy: ignored, including MTHI/MTLO. The pipeline must stall on busy.
- flush: in CALC or FIX, next state is IDLE, busy=0, done=0, hi/lo keep their pre-op values.
- flush with start in the same cycle: flush wins; nothing is accepted.
- flush in IDLE: no effect.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=32, FAST_MUL=0, MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles; done pulse the cycle after edge t33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with FAST_MUL=1 -> same values, done one cycle after t0, busy never set.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF after the full 33-cycle latency.
- MTHI 0x1234 then MTLO 0x5678 -> hi/lo update on their accept edges. Start DIVU, assert flush at edge t10 -> busy low after t10, no done, hi=0x1234, lo=0x5678.
- Start MULTU, then a second start (MTLO 0xAAAA) at t5 -> ignored; lo equals the product. Assert rst at t20 of another op -> hi=lo=0, busy=0 immediately.
